// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / hazard unit.
// The scoreboard entry carries a fixed-width rd field so the struct can live
// in a non-parameterised package; instances narrower than FWD_RD_W zero-extend.
package fwd_pkg;

  localparam int FWD_RD_W         = 8;   // widest supported register address
  localparam int ZERO_REG_DEFAULT = 31;  // hardwired-zero register
  localparam int SEL_REGFILE      = 0;   // select value meaning "use regfile / arch flags"
  localparam int SEL_STAGE_OFFSET = 1;   // select value for stage k is k + offset

  typedef struct packed {
    logic                valid;
    logic [FWD_RD_W-1:0] rd;
    logic                regwrite;
    logic                memread;
    logic                flagwrite;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

endpackage

// File: rtl/fwd_port_match.sv
// Priority scan of the scoreboard for a single decode source address.
// Returns the forwarding select of the youngest matching writer and whether
// that writer is a load whose data is not yet available.
module fwd_port_match
  import fwd_pkg::*;
#(
  parameter int STAGES     = 2,
  parameter int REG_AW     = 5,
  parameter int ZERO_REG   = ZERO_REG_DEFAULT,
  parameter int LOAD_READY = 1,
  parameter int SEL_W      = $clog2(STAGES + 1)
) (
  input  sb_entry_t         entries_i [STAGES],
  input  logic [REG_AW-1:0] src_addr_i,
  output logic [SEL_W-1:0]  sel_o,
  output logic              load_nr_o
);

  localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(ZERO_REG);

  logic [FWD_RD_W-1:0] src_ext;
  assign src_ext = FWD_RD_W'(src_addr_i);

  // Scan oldest to youngest so the youngest (lowest index) match is kept last.
  always_comb begin
    sel_o     = SEL_W'(SEL_REGFILE);
    load_nr_o = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (entries_i[k].valid && entries_i[k].regwrite &&
          (entries_i[k].rd == src_ext) && (src_addr_i != ZERO_ADDR)) begin
        sel_o     = SEL_W'(k + SEL_STAGE_OFFSET);
        load_nr_o = entries_i[k].memread && (k < LOAD_READY);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select, flag-forwarding select and load-use stall generator.
// Tracks in-flight writers in a shift-register scoreboard (entry 0 = EX).
// Optional statistics counters are enabled with `define FWD_HAZARD_STATS_EN.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int STAGES     = 2,
  parameter int REG_AW     = 5,
  parameter int ZERO_REG   = ZERO_REG_DEFAULT,
  parameter int LOAD_READY = 1,
  parameter int SEL_W      = $clog2(STAGES + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        id_valid,
  input  logic [NUM_PORTS*REG_AW-1:0] id_src_addr,
  input  logic [REG_AW-1:0]           id_rd,
  input  logic                        id_regwrite,
  input  logic                        id_memread,
  input  logic                        id_flagwrite,
  input  logic                        id_uncond_br,
  input  logic                        flush,
  output logic [NUM_PORTS*SEL_W-1:0]  fwd_sel,
  output logic [SEL_W-1:0]            flag_fwd_sel,
  output logic                        stall
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [31:0]                 stall_cycles,
  output logic [31:0]                 fwd_events
`endif
);

  sb_entry_t            entries_q [STAGES];
  sb_entry_t            entries_d [STAGES];
  sb_entry_t            head_d;
  logic [NUM_PORTS-1:0] port_load_nr;
  logic [SEL_W-1:0]     flag_sel;

  // One matcher per decode source port.
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      fwd_port_match #(
        .STAGES     (STAGES),
        .REG_AW     (REG_AW),
        .ZERO_REG   (ZERO_REG),
        .LOAD_READY (LOAD_READY),
        .SEL_W      (SEL_W)
      ) u_match (
        .entries_i  (entries_q),
        .src_addr_i (id_src_addr[gi*REG_AW +: REG_AW]),
        .sel_o      (fwd_sel[gi*SEL_W +: SEL_W]),
        .load_nr_o  (port_load_nr[gi])
      );
    end
  endgenerate

  // A real decode instruction whose youngest producer is an unready load must wait.
  assign stall = id_valid & (|port_load_nr);

  // Youngest flag setter wins; unconditional branches and empty slots ignore flags.
  always_comb begin
    flag_sel = SEL_W'(SEL_REGFILE);
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (entries_q[k].valid && entries_q[k].flagwrite) begin
        flag_sel = SEL_W'(k + SEL_STAGE_OFFSET);
      end
    end
    if (id_uncond_br || !id_valid) begin
      flag_sel = SEL_W'(SEL_REGFILE);
    end
  end

  assign flag_fwd_sel = flag_sel;

  // New EX entry: the decode instruction, or a bubble on stall/flush.
  always_comb begin
    head_d = SB_BUBBLE;
    if (!flush && !stall) begin
      head_d.valid     = id_valid;
      head_d.rd        = FWD_RD_W'(id_rd);
      head_d.regwrite  = id_regwrite;
      head_d.memread   = id_memread;
      head_d.flagwrite = id_flagwrite;
    end
  end

  assign entries_d[0] = head_d;

  // Older entries shift down; a flush also squashes the instruction leaving EX.
  generate
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_shift
      if (gi == 1) begin : g_squash
        assign entries_d[gi] = flush ? SB_BUBBLE : entries_q[gi-1];
      end else begin : g_plain
        assign entries_d[gi] = entries_q[gi-1];
      end
    end
  endgenerate

  // Scoreboard register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        entries_q[k] <= SB_BUBBLE;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        entries_q[k] <= entries_d[k];
      end
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] fwd_events_q, fwd_events_d;

  // Saturating event counters.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    fwd_events_d   = fwd_events_q;
    if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (!stall && (|fwd_sel) && (fwd_events_q != '1)) begin
      fwd_events_d = fwd_events_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      fwd_events_q   <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      fwd_events_q   <= fwd_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign fwd_events   = fwd_events_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit with default parameters.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [9:0] id_src_addr;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;
  logic       id_flagwrite;
  logic       id_uncond_br;
  logic       flush;
  logic [3:0] fwd_sel;
  logic [1:0] flag_fwd_sel;
  logic       stall;
`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] fwd_events;
`endif

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_src_addr  (id_src_addr),
    .id_rd        (id_rd),
    .id_regwrite  (id_regwrite),
    .id_memread   (id_memread),
    .id_flagwrite (id_flagwrite),
    .id_uncond_br (id_uncond_br),
    .flush        (flush),
    .fwd_sel      (fwd_sel),
    .flag_fwd_sel (flag_fwd_sel),
    .stall        (stall)
`ifdef FWD_HAZARD_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .fwd_events   (fwd_events)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_id(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [4:0] rd, input logic rw, input logic mr,
                        input logic fw, input logic ub, input logic fl);
    id_valid     = v;
    id_src_addr  = {s1, s0};
    id_rd        = rd;
    id_regwrite  = rw;
    id_memread   = mr;
    id_flagwrite = fw;
    id_uncond_br = ub;
    flush        = fl;
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    set_id(1'b1, 5'd3, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #10;
    check("rst_fwd", 32'(fwd_sel), 32'd0);
    check("rst_flag", 32'(flag_fwd_sel), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: producer of r3
    set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t1_fwd", 32'(fwd_sel), 32'd0);
    check("t1_stall", 32'(stall), 32'd0);
    cyc();
    // T2: consumer of r3, producer in EX
    set_id(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fwd_ex", 32'(fwd_sel), 32'h1);
    cyc();
    // T3: consumer of r3, producer in MEM; this one writes r5
    set_id(1'b1, 5'd3, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fwd_mem", 32'(fwd_sel), 32'h2);
    cyc();
    // T4: second writer of r5
    set_id(1'b1, 5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fwd_p1_ex", 32'(fwd_sel), 32'h4);
    cyc();
    // T5: r5 in both EX and MEM -> youngest
    set_id(1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("youngest", 32'(fwd_sel), 32'h4);
    cyc();
    // T6: load r7
    set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t6_fwd", 32'(fwd_sel), 32'd0);
    cyc();
    // T7: load-use
    set_id(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ld_use_stall", 32'(stall), 32'd1);
    cyc();
    // T8: re-presented, load now in MEM
    check("ld_re_stall", 32'(stall), 32'd0);
    check("ld_re_fwd", 32'(fwd_sel), 32'h2);
    cyc();
    // T9: writer of zero register that also sets flags
    set_id(1'b1, 5'd0, 5'd0, 5'd31, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    // T10: consumer of r31, flag setter in EX
    set_id(1'b1, 5'd31, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("zero_fwd", 32'(fwd_sel), 32'd0);
    check("zero_stall", 32'(stall), 32'd0);
    check("flag_ex", 32'(flag_fwd_sel), 32'd1);
    set_id(1'b1, 5'd31, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("flag_uncond", 32'(flag_fwd_sel), 32'd0);
    set_id(1'b0, 5'd31, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("flag_novalid", 32'(flag_fwd_sel), 32'd0);
    set_id(1'b1, 5'd31, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    // T11: flag setter now in MEM; present load r9
    set_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("flag_mem", 32'(flag_fwd_sel), 32'd2);
    cyc();
    // T12: consumer of r9 stalls on load; flush in same cycle
    set_id(1'b1, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("fl_stall", 32'(stall), 32'd1);
    check("fl_fwd", 32'(fwd_sel), 32'h4);
    cyc();
    // T13: EX and MEM squashed; present load r12
    set_id(1'b1, 5'd0, 5'd9, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("post_fl_stall", 32'(stall), 32'd0);
    check("post_fl_fwd", 32'(fwd_sel), 32'd0);
    cyc();
    // T14: load-use on r12, then asynchronous reset mid-cycle
    set_id(1'b0, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("novalid_stall", 32'(stall), 32'd0);
    set_id(1'b1, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t14_stall", 32'(stall), 32'd1);
    check("t14_fwd", 32'(fwd_sel), 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst_stall", 32'(stall), 32'd0);
    check("arst_fwd", 32'(fwd_sel), 32'd0);
    check("arst_flag", 32'(flag_fwd_sel), 32'd0);
    #1;
    rst_n = 1'b1;
    #1;
    check("rel_stall", 32'(stall), 32'd0);
    cyc();
    check("rel_cyc_stall", 32'(stall), 32'd0);
    check("rel_cyc_fwd", 32'(fwd_sel), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the single-cycle forwarding mux decoder.
- Holds an internal scoreboard: a shift register of in-flight writers, one entry per post-decode stage (EX, MEM, ... up to the stage before register-file write).
- Per decode-stage source port, generates a forwarding select, a flag-forwarding select and a load-use stall.
- Inserts bubbles into its own scoreboard on stall and flush.

Parameters:
- NUM_PORTS, 2, number of decode source-register ports.
- STAGES, 2, tracked stages after decode (index 0 = EX, 1 = MEM, ...).
- REG_AW, 5, register address width.
- ZERO_REG, 31, hardwired-zero register; never forwarded, never causes stall.
- LOAD_READY, 1, first stage index whose result is valid for a load.
- SEL_W, $clog2(STAGES+1), select width (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_src_addr  in  NUM_PORTS*REG_AW  source addresses, port p at [p*REG_AW +: REG_AW].
- id_rd  in  REG_AW  decode instruction destination.
- id_regwrite  in  1  decode instruction writes id_rd.
- id_memread  in  1  decode instruction is a load.
- id_flagwrite  in  1  decode instruction sets flags.
- id_uncond_br  in  1  decode instruction is unconditional branch (ignores flags).
- flush  in  1  squash decode and stage-0 instructions.
- fwd_sel  out  NUM_PORTS*SEL_W  per port: 0 = regfile, k = stage k-1 result.
- flag_fwd_sel  out  SEL_W  0 = architectural flags, k = stage k-1 flags.
- stall  out  1  hold PC/decode, inject bubble.

Behaviour:
- Entry fields: valid, rd, regwrite, memread, flagwrite.
- Reset (async, rst_n low):
  - all entries cleared (valid=0).
  - fwd_sel, flag_fwd_sel, stall are 0 while in reset.
- Outputs are combinational from the entries plus the id_* inputs; no added latency.
- Forward match for port p at stage k:
  - entry[k].valid, regwrite, rd==src_p, src_p != ZERO_REG.
  - Youngest (lowest k) match wins; fwd_sel_p = k+1, else 0.
- Load-use hazard: youngest match for any port has memread=1 and k < LOAD_READY.
  - Then stall=1, only when id_valid=1.
  - fwd_sel for a stalled port is still driven but is don't-care.
- Flag forwarding:
  - Youngest k with valid and flagwrite gives flag_fwd_sel = k+1.
  - Forced to 0 if id_uncond_br=1 or id_valid=0.
- Clock edge, shift: entry[k] <= entry[k-1] for k >= 1, then entry[0] is updated as follows:
  - Normal: entry[0] <= decode fields, valid = id_valid.
  - stall=1: entry[0] <= bubble; decode is re-presented next cycle.
  - flush=1: entry[0] <= bubble and entry[1] <= bubble (stage-0 instruction squashed); flush overrides stall.
- STAGES=1: flush clears entry[0] only.
- Oldest entry drops off each cycle; no wrap.
- Reset mid-operation: entries cleared immediately, asynchronously; no stall on the first cycle after release.
- Producer with regwrite=0 or rd=ZERO_REG: never matches.

Optional Feature:
- FWD_HAZARD_STATS_EN defined:
  - Adds outputs stall_cycles[31:0] and fwd_events[31:0].
  - stall_cycles increments each cycle stall=1.
  - fwd_events increments each cycle any fwd_sel is nonzero while stall=0.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and counters absent; otherwise identical.

Decomposition:
- Package fwd_pkg:
  - scoreboard entry struct.
  - ZERO_REG default.
  - select encoding constants: SEL_REGFILE=0, stage offset 1.
- Sub-module fwd_port_match:
  - One per port (generate loop).
  - Priority-scans entries for one source address.
  - Returns select plus a load-not-ready flag.

Test Plan:
- Defaults. Producer id_rd=3 regwrite issued, next cycle consumer src0=3 → fwd_sel0=1. One cycle later, same src → fwd_sel0=2.
- Two producers of X5 in EX and MEM, consumer src1=5 → fwd_sel1=1 (youngest wins).
- Load id_rd=7 memread, next cycle src0=7 → stall=1 for exactly 1 cycle. Re-presented cycle: stall=0, fwd_sel0=2.
- Producer rd=31 regwrite → consumer src0=31 gives fwd_sel0=0, stall=0.
- Flag setter in EX: consumer id_uncond_br=0 → flag_fwd_sel=1; consumer id_uncond_br=1 → 0.
- Load in EX, consumer stalling, flush=1 same cycle → next cycle entry[0] and entry[1] invalid, stall=0.
- rst_n pulled low mid-sequence → all outputs 0 asynchronously.
